pll_clock_supervisor: RTL and testbench

PLL_CLOCK_SUPERVISOR -- requirements
Module: pll_clock_supervisor

---
 rtl/pll_supervisor_pkg.sv | 30 +++
 rtl/sync_edge_detect.sv | 30 +++
 rtl/pll_clock_supervisor.sv | 175 +++++++++++++++++
 tb/tb_pll_clock_supervisor.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_supervisor_pkg.sv
// Shared types, widths and default constants for the PLL clock supervisor.
package pll_supervisor_pkg;

    localparam int unsigned CountW          = 12;
    localparam int unsigned DefRatio        = 36;
    localparam int unsigned DefWindow       = 16;
    localparam int unsigned DefTol          = 4;
    localparam int unsigned DefStableCycles = 1024;
    localparam int unsigned DefRefTimeout   = 128;

    typedef enum logic [1:0] {
        StWaitLock,
        StStabilize,
        StMeasure,
        StRun
    } state_e;

    // True when |count - target| <= tol.
    function automatic logic in_tolerance(input logic [CountW-1:0] count,
                                          input int unsigned target,
                                          input int unsigned tol);
        int unsigned c;
        c = int'(count);
        if (c >= target) begin
            return (c - target) <= tol;
        end
        return (target - c) <= tol;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer with a registered rising-edge pulse.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise
);

    logic meta_q, sync_q, prev_q, rise_q;

    // Synchronize, keep a delayed copy, and register the 0->1 transition.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
        end
    end

    assign level = sync_q;
    assign rise  = rise_q;

endmodule

// File: rtl/pll_clock_supervisor.sv
// Holds downstream logic in reset until the PLL is locked, stable, and its
// output frequency matches the reference over a measurement window.
module pll_clock_supervisor
    import pll_supervisor_pkg::*;
#(
    parameter int unsigned RATIO         = DefRatio,
    parameter int unsigned WINDOW        = DefWindow,
    parameter int unsigned TOL           = DefTol,
    parameter int unsigned STABLE_CYCLES = DefStableCycles,
    parameter int unsigned REF_TIMEOUT   = DefRefTimeout
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pll_lock,
    input  logic              ref_clk,
    input  logic              clear_flags,
    output logic              sys_reset,
    output logic              ratio_ok,
    output logic [CountW-1:0] ratio_count,
    output logic              meas_valid,
    output logic              lock_lost,
    output logic              ref_missing
);

    localparam int unsigned Target  = RATIO * WINDOW;
    localparam int unsigned EdgeW   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int unsigned StableW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned ToW     = $clog2(REF_TIMEOUT + 1);

    logic lock_s, lock_rise_unused, ref_level_unused, ref_edge;

    sync_edge_detect u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .din   (pll_lock),
        .level (lock_s),
        .rise  (lock_rise_unused)
    );

    sync_edge_detect u_ref_sync (
        .clk   (clk),
        .reset (reset),
        .din   (ref_clk),
        .level (ref_level_unused),
        .rise  (ref_edge)
    );

    state_e             state_q, state_d;
    logic [StableW-1:0] stable_q, stable_d;
    logic [CountW-1:0]  win_cnt_q, win_cnt_d, ratio_count_q, ratio_count_d;
    logic [EdgeW-1:0]   edge_cnt_q, edge_cnt_d;
    logic [ToW-1:0]     to_cnt_q, to_cnt_d;
    logic               win_active_q, win_active_d;
    logic               ratio_ok_q, ratio_ok_d, meas_valid_q, meas_valid_d;
    logic               lock_lost_q, lock_lost_d, ref_missing_q, ref_missing_d;
    logic               measuring, timeout;

    assign measuring = (state_q == StMeasure) || (state_q == StRun);
    // Cycle counter holds cycles since the last ref edge; last idle cycle is the trip point.
    assign timeout   = measuring && !ref_edge && (to_cnt_q == ToW'(REF_TIMEOUT - 1));

    // Next-state: lock drop beats timeout, which beats a completed measurement.
    always_comb begin
        state_d       = state_q;
        stable_d      = stable_q;
        win_active_d  = win_active_q;
        win_cnt_d     = !win_active_q ? '0 : (&win_cnt_q ? win_cnt_q : win_cnt_q + 1'b1);
        edge_cnt_d    = edge_cnt_q;
        to_cnt_d      = (measuring && !ref_edge) ? to_cnt_q + 1'b1 : '0;
        ratio_count_d = ratio_count_q;
        ratio_ok_d    = ratio_ok_q;
        meas_valid_d  = 1'b0;
        lock_lost_d   = lock_lost_q & ~clear_flags;
        ref_missing_d = ref_missing_q & ~clear_flags;

        if (!lock_s) begin
            state_d      = StWaitLock;
            win_active_d = 1'b0;
            win_cnt_d    = '0;
            edge_cnt_d   = '0;
            to_cnt_d     = '0;
            ratio_ok_d   = 1'b0;
            if (state_q == StRun) begin
                lock_lost_d = 1'b1;
            end
        end else if (timeout) begin
            state_d       = StMeasure;
            win_active_d  = 1'b0;
            win_cnt_d     = '0;
            edge_cnt_d    = '0;
            to_cnt_d      = '0;
            ratio_ok_d    = 1'b0;
            ref_missing_d = 1'b1;
        end else begin
            if (measuring && ref_edge) begin
                if (!win_active_q) begin
                    win_active_d = 1'b1;
                    win_cnt_d    = CountW'(1);
                    edge_cnt_d   = '0;
                end else if (edge_cnt_q == EdgeW'(WINDOW - 1)) begin
                    ratio_count_d = win_cnt_q;
                    ratio_ok_d    = in_tolerance(win_cnt_q, Target, TOL);
                    meas_valid_d  = 1'b1;
                    win_cnt_d     = CountW'(1);
                    edge_cnt_d    = '0;
                end else begin
                    edge_cnt_d = edge_cnt_q + 1'b1;
                end
            end

            unique case (state_q)
                StWaitLock: begin
                    state_d  = StStabilize;
                    stable_d = '0;
                end
                StStabilize: begin
                    if (stable_q == StableW'(STABLE_CYCLES - 1)) begin
                        state_d      = StMeasure;
                        win_active_d = 1'b0;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end
                StMeasure: begin
                    if (meas_valid_q && ratio_ok_q) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (meas_valid_q && !ratio_ok_q) begin
                        state_d = StMeasure;
                    end
                end
                default: state_d = StWaitLock;
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StWaitLock;
            stable_q      <= '0;
            win_active_q  <= 1'b0;
            win_cnt_q     <= '0;
            edge_cnt_q    <= '0;
            to_cnt_q      <= '0;
            ratio_count_q <= '0;
            ratio_ok_q    <= 1'b0;
            meas_valid_q  <= 1'b0;
            lock_lost_q   <= 1'b0;
            ref_missing_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stable_q      <= stable_d;
            win_active_q  <= win_active_d;
            win_cnt_q     <= win_cnt_d;
            edge_cnt_q    <= edge_cnt_d;
            to_cnt_q      <= to_cnt_d;
            ratio_count_q <= ratio_count_d;
            ratio_ok_q    <= ratio_ok_d;
            meas_valid_q  <= meas_valid_d;
            lock_lost_q   <= lock_lost_d;
            ref_missing_q <= ref_missing_d;
        end
    end

    assign sys_reset   = (state_q != StRun);
    assign ratio_ok    = ratio_ok_q;
    assign ratio_count = ratio_count_q;
    assign meas_valid  = meas_valid_q;
    assign lock_lost   = lock_lost_q;
    assign ref_missing = ref_missing_q;

endmodule

// File: tb/tb_pll_clock_supervisor.sv
// Scoreboard bench: directed scenarios push expected window results, a
// negedge monitor pops and compares them whenever meas_valid pulses.
module tb_pll_clock_supervisor;
    import pll_supervisor_pkg::*;

    logic              clk = 1'b0;
    logic              reset, pll_lock, ref_clk, clear_flags;
    logic              sys_reset, ratio_ok, meas_valid, lock_lost, ref_missing;
    logic [CountW-1:0] ratio_count;

    pll_clock_supervisor dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .ref_clk     (ref_clk),
        .clear_flags (clear_flags),
        .sys_reset   (sys_reset),
        .ratio_ok    (ratio_ok),
        .ratio_count (ratio_count),
        .meas_valid  (meas_valid),
        .lock_lost   (lock_lost),
        .ref_missing (ref_missing)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned count;
        logic        ok;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          checks = 0;
    int          failures = 0;
    int unsigned cyc = 0;
    int unsigned n_meas = 0;
    int unsigned r, m0;
    logic        mv_sys_reset = 1'b0;

    // Reference generator state.
    int unsigned ref_period = 36;
    int unsigned gcnt = 0;
    int unsigned rise_cyc = 0;
    bit          hold_req = 1'b0;
    bit          hold_q = 1'b0;
    bit          ref_prev = 1'b0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sys_reset"}, sys_reset, 1);
        check({tag, "_ratio_ok"}, ratio_ok, 0);
        check({tag, "_ratio_count"}, ratio_count, 0);
        check({tag, "_meas_valid"}, meas_valid, 0);
        check({tag, "_lock_lost"}, lock_lost, 0);
        check({tag, "_ref_missing"}, ref_missing, 0);
    endtask

    // Advance to 2 time units after the n-th next rising clk edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int bound, input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < bound) begin
            step(1);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s: actual %0d windows pending after %0d cycles, required 0",
                     name, sb.size(), bound);
            sb.delete();
        end
    endtask

    task automatic wait_rise(input string name);
        int n;
        n = 0;
        do begin
            step(1);
            n++;
        end while (rise_cyc != cyc && n < 100);
        checks++;
        if (rise_cyc != cyc) begin
            failures++;
            $display("FAIL %s: actual no ref rise in 100 cycles, required a rise", name);
        end
    endtask

    task automatic push(input int unsigned count, input logic ok);
        exp_t x;
        x.count = count;
        x.ok    = ok;
        sb.push_back(x);
    endtask

    // Cycle counter.
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Reference clock: period ref_period, high for the first half. A hold
    // forces it low at once but releases only on a period boundary.
    initial begin
        ref_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (gcnt >= ref_period - 1) gcnt = 0;
            else gcnt++;
            if (gcnt == 0) hold_q = hold_req;
            else if (hold_req) hold_q = 1'b1;
            ref_clk = !hold_q && (gcnt < ref_period / 2);
            if (ref_clk && !ref_prev) rise_cyc = cyc;
            ref_prev = ref_clk;
        end
    end

    // Monitor: compare every presented measurement against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (!reset && meas_valid) begin
            n_meas++;
            mv_sys_reset = sys_reset;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_meas_valid: actual count %0d, required no pulse",
                         ratio_count);
            end else begin
                e = sb.pop_front();
                check("ratio_count", ratio_count, e.count);
                check("ratio_ok", ratio_ok, e.ok);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        pll_lock    = 1'b0;
        clear_flags = 1'b0;
        #1;
        check_reset_outputs("por");
        step(3);
        reset = 1'b0;

        // Lock from cycle 10, first window 36*16 = 576 in tolerance.
        while (cyc < 10) step(1);
        pll_lock = 1'b1;
        push(576, 1'b1);
        wait_drain(3000, "first_window");
        check("sysrst_in_latch_cycle", mv_sys_reset, 1);
        check("sysrst_after_first_ok", sys_reset, 0);

        // Slow reference: 37*16 = 592 is out of tolerance, back to MEASURE.
        ref_period = 37;
        push(592, 1'b0);
        wait_drain(1000, "slow_window");
        check("sysrst_after_bad_window", sys_reset, 1);
        ref_period = 36;
        push(576, 1'b1);
        wait_drain(1000, "recover_window");
        check("sysrst_after_recover", sys_reset, 0);

        // One-cycle lock drop in RUN.
        pll_lock = 1'b0;
        step(1);
        pll_lock = 1'b1;
        step(4);
        check("lock_lost_set", lock_lost, 1);
        check("sysrst_after_lock_drop", sys_reset, 1);
        step(50);
        check("lock_lost_sticky", lock_lost, 1);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("lock_lost_cleared", lock_lost, 0);
        push(576, 1'b1);
        wait_drain(3000, "relock_window");
        check("sysrst_after_relock", sys_reset, 0);

        // Reference held low: timeout 128 cycles after the last detected edge.
        wait_rise("rise_before_hold");
        hold_req = 1'b1;
        r = rise_cyc;
        while (cyc < r + 131) step(1);
        check("ref_missing_before_timeout", ref_missing, 0);
        step(1);
        check("ref_missing_at_timeout", ref_missing, 1);
        check("sysrst_after_timeout", sys_reset, 1);
        check("ratio_ok_after_timeout", ratio_ok, 0);
        while (cyc < r + 200) step(1);
        push(576, 1'b1);
        hold_req = 1'b0;
        wait_drain(2000, "ref_restored_window");
        check("sysrst_after_ref_restore", sys_reset, 0);
        check("ref_missing_sticky", ref_missing, 1);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("ref_missing_cleared", ref_missing, 0);

        // Lock drop lands on the timeout cycle, with clear_flags in that cycle too.
        wait_rise("rise_before_combo");
        hold_req = 1'b1;
        r = rise_cyc;
        while (cyc < r + 129) step(1);
        pll_lock = 1'b0;
        step(2);
        clear_flags = 1'b1;
        step(1);
        clear_flags = 1'b0;
        check("combo_lock_lost", lock_lost, 1);
        check("combo_ref_missing", ref_missing, 0);
        check("combo_sys_reset", sys_reset, 1);
        pll_lock = 1'b1;
        hold_req = 1'b0;
        push(576, 1'b1);
        wait_drain(3000, "combo_relock_window");
        push(576, 1'b1);
        wait_drain(1000, "pre_reset_window");

        // Reset mid-window (window count 2 now, 300 after 298 more cycles).
        step(298);
        reset = 1'b1;
        #1;
        check_reset_outputs("mid_window_reset");
        step(3);
        check("meas_valid_in_reset", meas_valid, 0);
        reset = 1'b0;
        m0 = n_meas;
        step(600);
        check("no_meas_after_reset", n_meas, m0);
        check("sysrst_after_reset", sys_reset, 1);
        check("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
